// File: rtl/core_array_mem_fabric.sv
// Core-array memory fabric.
// Decodes host memory requests onto CORE_NUM per-core memory ports through a
// registered stage, tracks outstanding unicast reads in order, reports
// protocol/decode errors through a sticky flag, and aggregates per-core
// finish pulses under an enable mask.
module core_array_mem_fabric #(
  parameter int CORE_NUM    = 8,
  parameter int SEL_W       = 4,
  parameter int CORE_ADDR_W = 14,
  parameter int ADDR_W      = CORE_ADDR_W + SEL_W + 2,
  parameter int DATA_W      = 32,
  parameter int OT_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  // host request port
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  logic [ADDR_W-1:0]               req_addr,
  input  logic                            req_wen,
  input  logic                            req_ren,
  input  logic [DATA_W-1:0]               req_wdata,
  // host read response
  output logic                            rsp_vld,
  output logic [DATA_W-1:0]               rsp_rdata,
  // sticky error
  output logic                            err,
  input  logic                            err_clr,
  // per-core memory ports
  output logic [CORE_NUM*CORE_ADDR_W-1:0] core_addr,
  output logic [CORE_NUM*DATA_W-1:0]      core_wdata,
  output logic [CORE_NUM-1:0]             core_wen,
  output logic [CORE_NUM-1:0]             core_ren,
  input  logic [CORE_NUM-1:0]             core_rvld,
  input  logic [CORE_NUM*DATA_W-1:0]      core_rdata,
  // finish aggregation
  input  logic [CORE_NUM-1:0]             core_en,
  input  logic                            start,
  input  logic [CORE_NUM-1:0]             core_finish,
  output logic                            finish
);

  localparam int               PTR_W      = $clog2(OT_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W+1)'(OT_DEPTH);
  localparam logic [SEL_W:0]   CORE_NUM_L = (SEL_W+1)'(CORE_NUM);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CORE_NUM-1:0]    wen_q,   wen_d;
  logic [CORE_NUM-1:0]    ren_q,   ren_d;
  // One shared address/data register fans out to every core; only the
  // strobed cores act on it, so per-core copies would carry no information.
  logic [CORE_ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;

  logic [SEL_W-1:0]       fifo_q [OT_DEPTH];
  logic [SEL_W-1:0]       fifo_d [OT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         cnt_q,    cnt_d;

  logic                   rsp_vld_q,   rsp_vld_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                   err_q,       err_d;

  logic [CORE_NUM-1:0]    flag_q,   flag_d;
  logic                   finish_q, finish_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                   accept;
  logic                   addr_noncore;
  logic                   addr_bcast;
  logic [SEL_W-1:0]       addr_sel;
  logic [CORE_ADDR_W-1:0] addr_loc;
  logic                   sel_ok;
  logic [CORE_NUM-1:0]    sel_onehot;
  logic                   push;
  logic                   req_err;

  assign req_rdy      = (cnt_q != FULL_CNT);
  assign accept       = req_vld & req_rdy;
  assign addr_noncore = req_addr[ADDR_W-1];
  assign addr_bcast   = req_addr[ADDR_W-2];
  assign addr_sel     = req_addr[CORE_ADDR_W +: SEL_W];
  assign addr_loc     = req_addr[CORE_ADDR_W-1:0];
  assign sel_ok       = ({1'b0, addr_sel} < CORE_NUM_L);

  // One-hot core select; compare-based so a select wider than the core count
  // never indexes past the strobe vector.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      sel_onehot[i] = (addr_sel == SEL_W'(i));
    end
  end

  // Next-cycle strobes, shared addr/data, FIFO push and decode errors.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the if/else tree can leave a value unassigned and infer a latch.
    wen_d   = '0;
    ren_d   = '0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    push    = 1'b0;
    req_err = 1'b0;
    if (accept) begin
      if (req_wen && req_ren) begin
        req_err = 1'b1;
      end else if (addr_noncore) begin
        // Non-core region: accepted and silently ignored.
      end else if (addr_bcast) begin
        if (req_ren) begin
          req_err = 1'b1;
        end else if (req_wen) begin
          wen_d   = core_en;
          addr_d  = addr_loc;
          wdata_d = req_wdata;
        end
      end else if (!sel_ok) begin
        req_err = req_wen | req_ren;
      end else if (req_wen) begin
        wen_d   = sel_onehot;
        addr_d  = addr_loc;
        wdata_d = req_wdata;
      end else if (req_ren) begin
        ren_d  = sel_onehot;
        addr_d = addr_loc;
        push   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-read FIFO and response path
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]    head;
  logic [CORE_NUM-1:0] head_onehot;
  logic                head_hit;
  logic [DATA_W-1:0]   head_data;
  logic                fifo_empty;
  logic                pop;
  logic                rsp_err;

  assign head       = fifo_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);

  // Select the valid/data of the core at the FIFO head.
  always_comb begin
    head_onehot = '0;
    head_hit    = 1'b0;
    head_data   = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (head == SEL_W'(i)) begin
        head_onehot[i] = 1'b1;
        head_hit       = core_rvld[i];
        head_data      = core_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pop on a head match; any other valid bit is unexpected and flags an error.
  always_comb begin
    pop         = !fifo_empty && head_hit;
    rsp_err     = |(core_rvld & ~(pop ? head_onehot : '0));
    rsp_vld_d   = pop;
    rsp_rdata_d = pop ? head_data : rsp_rdata_q;
  end

  // FIFO storage write and pointer/count update.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = addr_sel;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Sticky error: a new error in the same cycle wins over a clear.
  always_comb begin
    if (req_err || rsp_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Finish aggregator
  // ---------------------------------------------------------------------------
  logic all_done;

  // The current cycle's finish pulses count, so finish rises one cycle after
  // the last enabled core reports; start suppresses completion and wins.
  always_comb begin
    all_done = !start && (|core_en) && (&(flag_q | core_finish | ~core_en));
    finish_d = all_done;
    if (start || all_done) begin
      flag_d = '0;
    end else begin
      flag_d = flag_q | core_finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register samples the pre-edge
    // value of the others, independent of statement order.
    if (rst) begin
      wen_q       <= '0;
      ren_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      flag_q      <= '0;
      finish_q    <= 1'b0;
    end else begin
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      flag_q      <= flag_d;
      finish_q    <= finish_d;
    end
  end

  // FIFO entry storage.
  always_ff @(posedge clk) begin
    // NOTE: entries are not reset; the cleared count and pointers already mark
    // every slot invalid, so resetting the array would only add reset fanout.
    fifo_q <= fifo_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign core_wen   = wen_q;
  assign core_ren   = ren_q;
  assign core_addr  = {CORE_NUM{addr_q}};
  assign core_wdata = {CORE_NUM{wdata_q}};
  assign rsp_vld    = rsp_vld_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign err        = err_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_core_array_mem_fabric.sv
// Directed testbench for core_array_mem_fabric: unicast/broadcast decode,
// error cases, in-order read tracking with a response scoreboard, finish
// aggregation and mid-operation reset.
module tb_core_array_mem_fabric;

  localparam int CORE_NUM    = 8;
  localparam int SEL_W       = 4;
  localparam int CORE_ADDR_W = 14;
  localparam int ADDR_W      = CORE_ADDR_W + SEL_W + 2;
  localparam int DATA_W      = 32;
  localparam int OT_DEPTH    = 4;

  logic                            clk;
  logic                            rst;
  logic                            req_vld;
  logic                            req_rdy;
  logic [ADDR_W-1:0]               req_addr;
  logic                            req_wen;
  logic                            req_ren;
  logic [DATA_W-1:0]               req_wdata;
  logic                            rsp_vld;
  logic [DATA_W-1:0]               rsp_rdata;
  logic                            err;
  logic                            err_clr;
  logic [CORE_NUM*CORE_ADDR_W-1:0] core_addr;
  logic [CORE_NUM*DATA_W-1:0]      core_wdata;
  logic [CORE_NUM-1:0]             core_wen;
  logic [CORE_NUM-1:0]             core_ren;
  logic [CORE_NUM-1:0]             core_rvld;
  logic [CORE_NUM*DATA_W-1:0]      core_rdata;
  logic [CORE_NUM-1:0]             core_en;
  logic                            start;
  logic [CORE_NUM-1:0]             core_finish;
  logic                            finish;

  int n_err = 0;
  int n_chk = 0;

  // Expected read-response data, pushed when a read is issued.
  logic [DATA_W-1:0] exp_q[$];

  core_array_mem_fabric #(
    .CORE_NUM   (CORE_NUM),
    .SEL_W      (SEL_W),
    .CORE_ADDR_W(CORE_ADDR_W),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .OT_DEPTH   (OT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_ren    (req_ren),
    .req_wdata  (req_wdata),
    .rsp_vld    (rsp_vld),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .err_clr    (err_clr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wen   (core_wen),
    .core_ren   (core_ren),
    .core_rvld  (core_rvld),
    .core_rdata (core_rdata),
    .core_en    (core_en),
    .start      (start),
    .core_finish(core_finish),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_vld     = 1'b0;
    req_wen     = 1'b0;
    req_ren     = 1'b0;
    err_clr     = 1'b0;
    start       = 1'b0;
    core_finish = '0;
    core_rvld   = '0;
  endtask

  function automatic logic [ADDR_W-1:0] mk_addr(input logic noncore, input logic bc,
                                                 input logic [SEL_W-1:0] s,
                                                 input logic [CORE_ADDR_W-1:0] l);
    return {noncore, bc, s, l};
  endfunction

  task automatic drive_req(input logic wen, input logic ren, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    req_vld   = 1'b1;
    req_wen   = wen;
    req_ren   = ren;
    req_addr  = a;
    req_wdata = d;
  endtask

  int order[4] = '{1, 5, 2, 7};

  initial begin
    rst        = 1'b1;
    req_addr   = '0;
    req_wdata  = '0;
    core_rdata = '0;
    core_en    = '0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("reset_rdy",  64'(req_rdy),  64'h1);
    check("reset_wen",  64'(core_wen), 64'h0);
    check("reset_ren",  64'(core_ren), 64'h0);
    check("reset_err",  64'(err),      64'h0);
    check("reset_rsp",  64'(rsp_vld),  64'h0);
    check("reset_fin",  64'(finish),   64'h0);

    // Unicast write to core 3
    drive_req(1'b1, 1'b0, mk_addr(1'b0, 1'b0, 4'd3, 14'h12A), 32'hDEADBEEF);
    step();
    idle();
    check("uwr_wen",   64'(core_wen), 64'h08);
    check("uwr_addr3", 64'(core_addr[3*CORE_ADDR_W +: CORE_ADDR_W]), 64'h12A);
    check("uwr_data3", 64'(core_wdata[3*DATA_W +: DATA_W]), 64'hDEADBEEF);
    step();
    check("uwr_single", 64'(core_wen), 64'h00);
    check("uwr_noerr",  64'(err),      64'h0);

    // Broadcast write with core_en = F0
    core_en = 8'hF0;
    drive_req(1'b1, 1'b0, mk_addr(1'b0, 1'b1, 4'd0, 14'h055), 32'h12345678);
    step();
    idle();
    check("bwr_wen",   64'(core_wen), 64'hF0);
    check("bwr_addr4", 64'(core_addr[4*CORE_ADDR_W +: CORE_ADDR_W]), 64'h055);
    check("bwr_addr7", 64'(core_addr[7*CORE_ADDR_W +: CORE_ADDR_W]), 64'h055);
    check("bwr_data7", 64'(core_wdata[7*DATA_W +: DATA_W]), 64'h12345678);
    step();
    check("bwr_single", 64'(core_wen), 64'h00);

    // Broadcast read is an error
    drive_req(1'b0, 1'b1, mk_addr(1'b0, 1'b1, 4'd0, 14'h010), 32'h0);
    step();
    idle();
    check("brd_ren", 64'(core_ren), 64'h00);
    check("brd_wen", 64'(core_wen), 64'h00);
    check("brd_err", 64'(err),      64'h1);
    err_clr = 1'b1;
    step();
    idle();
    check("brd_clr", 64'(err), 64'h0);

    // Four back-to-back reads to cores 1,5,2,7
    for (int j = 0; j < 4; j++) begin
      drive_req(1'b0, 1'b1, mk_addr(1'b0, 1'b0, SEL_W'(order[j]), CORE_ADDR_W'(14'h40 + order[j])),
                32'h0);
      exp_q.push_back(32'hA0 | 32'(order[j]));
      step();
      check($sformatf("rd%0d_ren", j), 64'(core_ren), 64'(8'(1) << order[j]));
      check($sformatf("rd%0d_rdy", j), 64'(req_rdy), (j == 3) ? 64'h0 : 64'h1);
    end
    idle();
    step();
    check("full_rdy_hold", 64'(req_rdy),  64'h0);
    check("full_ren_idle", 64'(core_ren), 64'h00);

    // Out-of-order valid from core 5 while core 1 is at the head
    core_rvld = 8'h20;
    core_rdata[5*DATA_W +: DATA_W] = 32'hBAD5;
    step();
    idle();
    check("ooo_rsp", 64'(rsp_vld), 64'h0);
    check("ooo_err", 64'(err),     64'h1);
    check("ooo_rdy", 64'(req_rdy), 64'h0);
    err_clr = 1'b1;
    step();
    idle();
    check("ooo_clr", 64'(err), 64'h0);

    // In-order responses checked against the scoreboard
    for (int j = 0; j < 4; j++) begin
      logic [DATA_W-1:0] exp_d;
      core_rvld = 8'(1) << order[j];
      core_rdata[order[j]*DATA_W +: DATA_W] = 32'hA0 | 32'(order[j]);
      step();
      idle();
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL rsp%0d scoreboard empty", j);
      end else begin
        exp_d = exp_q.pop_front();
        check($sformatf("rsp%0d_vld", j),   64'(rsp_vld),   64'h1);
        check($sformatf("rsp%0d_data", j),  64'(rsp_rdata), 64'(exp_d));
      end
      if (j == 0) check("rdy_after_pop", 64'(req_rdy), 64'h1);
    end
    step();
    check("rsp_pulse_end", 64'(rsp_vld), 64'h0);
    check("rsp_noerr",     64'(err),     64'h0);

    // Finish aggregation, core_en = 0F, extra finish on core 6
    core_en = 8'h0F;
    start = 1'b1;
    step();
    idle();
    core_finish = 8'h01; step(); check("fin_c0", 64'(finish), 64'h0);
    core_finish = 8'h42; step(); check("fin_c1", 64'(finish), 64'h0);
    core_finish = 8'h04; step(); check("fin_c2", 64'(finish), 64'h0);
    core_finish = 8'h08; step(); check("fin_c3", 64'(finish), 64'h1);
    idle();
    step();
    check("fin_pulse_end", 64'(finish), 64'h0);

    // start and core_finish[0] together: the flag stays clear
    core_en = 8'h01;
    start = 1'b1;
    core_finish = 8'h01;
    step();
    idle();
    check("fin_start_prio", 64'(finish), 64'h0);
    step();
    check("fin_flag_clear", 64'(finish), 64'h0);
    core_finish = 8'h01;
    step();
    idle();
    check("fin_after_start", 64'(finish), 64'h1);
    step();

    // No enabled cores: finish never asserts
    core_en = 8'h00;
    core_finish = 8'hFF;
    step();
    idle();
    check("fin_none_en", 64'(finish), 64'h0);
    step();
    check("fin_none_en2", 64'(finish), 64'h0);

    // Select beyond CORE_NUM
    drive_req(1'b1, 1'b0, mk_addr(1'b0, 1'b0, 4'd9, 14'h001), 32'h5);
    step();
    idle();
    check("sel9_wen", 64'(core_wen), 64'h00);
    check("sel9_err", 64'(err),      64'h1);
    err_clr = 1'b1;
    step();
    idle();
    check("sel9_clr", 64'(err), 64'h0);

    // Non-core region: ignored, no error
    drive_req(1'b1, 1'b0, mk_addr(1'b1, 1'b0, 4'd2, 14'h002), 32'h6);
    step();
    idle();
    check("noncore_wen", 64'(core_wen), 64'h00);
    check("noncore_err", 64'(err),      64'h0);

    // Reset in the middle of an outstanding read
    core_en = 8'hFF;
    drive_req(1'b0, 1'b1, mk_addr(1'b0, 1'b0, 4'd4, 14'h044), 32'h0);
    step();
    idle();
    check("mid_ren", 64'(core_ren), 64'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ren",  64'(core_ren),  64'h00);
    check("rst_wen",  64'(core_wen),  64'h00);
    check("rst_addr", 64'(core_addr), 64'h0);
    check("rst_rsp",  64'(rsp_vld),   64'h0);
    check("rst_err",  64'(err),       64'h0);
    check("rst_fin",  64'(finish),    64'h0);
    check("rst_rdy",  64'(req_rdy),   64'h1);

    // Late valid after reset is unexpected
    core_rvld = 8'h10;
    core_rdata[4*DATA_W +: DATA_W] = 32'hA4;
    step();
    idle();
    check("late_rsp", 64'(rsp_vld), 64'h0);
    check("late_err", 64'(err),     64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
